// File: rtl/hssim_pkg.sv
// Shared definitions for the HSSIM frame-score accumulator: width and
// latency derivations, the divider state encoding and saturation limits.
package hssim_pkg;

  // Divider sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Ceiling log2 for elaboration-time width derivation
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  // Beats needed to carry one square frame
  function automatic int beats_per_frame(input int image_dim, input int pixels_per_beat);
    return (image_dim * image_dim) / pixels_per_beat;
  endfunction

  // Frame-sum width: widest lane plus growth over every pixel, plus a guard bit
  function automatic int acc_width(input int numr_w, input int denr_w, input int image_dim);
    return ((numr_w > denr_w) ? numr_w : denr_w) + clog2(image_dim * image_dim) + 1;
  endfunction

  // One quotient bit per cycle over the whole shifted dividend
  function automatic int div_cycles(input int acc_w, input int frac_bits);
    return acc_w + frac_bits;
  endfunction

  // Largest positive score bit pattern for a signed score of width w
  function automatic logic [63:0] score_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative score bit pattern for width w (also its magnitude)
  function automatic logic [63:0] score_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/hssim_serial_div.sv
// Restoring signed divider producing a saturated Q(FRAC_BITS) score.
// Divides |num|<<FRAC_BITS by |den| one quotient bit per cycle, then applies
// the sign and saturates. A zero divisor skips the division and reports +max.
// Build option HSSIM_SCORE_ROUND_EN: adds |den|>>1 to the dividend so the
// magnitude rounds half-up instead of truncating toward zero.
module hssim_serial_div
  import hssim_pkg::*;
#(
  parameter int ACC_WIDTH   = 43,
  parameter int FRAC_BITS   = 16,
  parameter int SCORE_WIDTH = 18
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   start_i,
  input  logic [ACC_WIDTH-1:0]   num_i,
  input  logic [ACC_WIDTH-1:0]   den_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [SCORE_WIDTH-1:0] quot_o,
  output logic                   dz_o
);

  localparam int DW = div_cycles(ACC_WIDTH, FRAC_BITS);
  localparam int CW = clog2(DW) + 1;
  localparam logic [CW-1:0]          LAST_CNT = CW'(DW - 1);
  localparam logic [DW-1:0]          MAX_MAG  = DW'(score_max(SCORE_WIDTH));
  localparam logic [DW-1:0]          MIN_MAG  = DW'(score_min(SCORE_WIDTH));
  localparam logic [SCORE_WIDTH-1:0] SAT_POS  = SCORE_WIDTH'(score_max(SCORE_WIDTH));
  localparam logic [SCORE_WIDTH-1:0] SAT_NEG  = SCORE_WIDTH'(score_min(SCORE_WIDTH));

  div_state_e             state_q;
  logic [DW-1:0]          dvd_q;
  logic [ACC_WIDTH-1:0]   rem_q;
  logic [ACC_WIDTH-1:0]   dsr_q;
  logic                   neg_q;
  logic [CW-1:0]          cnt_q;
  logic [SCORE_WIDTH-1:0] result_q;
  logic                   dz_q;
  logic                   done_q;

  logic [ACC_WIDTH-1:0]   abs_n_s;
  logic [ACC_WIDTH-1:0]   abs_d_s;
  logic [DW-1:0]          dvd_init_s;
  logic [ACC_WIDTH:0]     rem_sh_s;
  logic [ACC_WIDTH:0]     diff_s;
  logic                   ge_s;
  logic [ACC_WIDTH-1:0]   rem_nx_s;
  logic [DW-1:0]          dvd_nx_s;
  logic [SCORE_WIDTH-1:0] sat_res_s;

  // Operand magnitudes; the most negative value maps to its exact magnitude
  always_comb begin
    abs_n_s = num_i;
    abs_d_s = den_i;
    if (num_i[ACC_WIDTH-1]) begin
      abs_n_s = ~num_i + ACC_WIDTH'(1);
    end else begin
      abs_n_s = num_i;
    end
    if (den_i[ACC_WIDTH-1]) begin
      abs_d_s = ~den_i + ACC_WIDTH'(1);
    end else begin
      abs_d_s = den_i;
    end
  end

  // Shifted dividend, optionally biased by half the divisor for rounding
  always_comb begin
    dvd_init_s = {abs_n_s, {FRAC_BITS{1'b0}}};
`ifdef HSSIM_SCORE_ROUND_EN
    dvd_init_s = {abs_n_s, {FRAC_BITS{1'b0}}}
               + {{(FRAC_BITS + 1){1'b0}}, abs_d_s[ACC_WIDTH-1:1]};
`else
    dvd_init_s = {abs_n_s, {FRAC_BITS{1'b0}}};
`endif
  end

  // One restoring step: quotient bits shift into the dividend register LSB
  always_comb begin
    rem_sh_s = {rem_q, dvd_q[DW-1]};
    diff_s   = rem_sh_s - {1'b0, dsr_q};
    ge_s     = ~diff_s[ACC_WIDTH];
    if (ge_s) begin
      rem_nx_s = diff_s[ACC_WIDTH-1:0];
    end else begin
      rem_nx_s = rem_sh_s[ACC_WIDTH-1:0];
    end
    dvd_nx_s = {dvd_q[DW-2:0], ge_s};
  end

  // Sign application and saturation of the final quotient magnitude
  always_comb begin
    sat_res_s = {SCORE_WIDTH{1'b0}};
    if (neg_q) begin
      if (dvd_nx_s >= MIN_MAG) begin
        sat_res_s = SAT_NEG;
      end else begin
        sat_res_s = ~dvd_nx_s[SCORE_WIDTH-1:0] + SCORE_WIDTH'(1);
      end
    end else begin
      if (dvd_nx_s > MAX_MAG) begin
        sat_res_s = SAT_POS;
      end else begin
        sat_res_s = dvd_nx_s[SCORE_WIDTH-1:0];
      end
    end
  end

  // Divider FSM: load on start, iterate DW cycles, pulse done with the result
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      dvd_q    <= {DW{1'b0}};
      rem_q    <= {ACC_WIDTH{1'b0}};
      dsr_q    <= {ACC_WIDTH{1'b0}};
      neg_q    <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      result_q <= {SCORE_WIDTH{1'b0}};
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            if (abs_d_s == {ACC_WIDTH{1'b0}}) begin
              result_q <= SAT_POS;
              dz_q     <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              dvd_q   <= dvd_init_s;
              rem_q   <= {ACC_WIDTH{1'b0}};
              dsr_q   <= abs_d_s;
              neg_q   <= num_i[ACC_WIDTH-1] ^ den_i[ACC_WIDTH-1];
              cnt_q   <= {CW{1'b0}};
              state_q <= ST_DIV;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DIV: begin
          rem_q <= rem_nx_s;
          dvd_q <= dvd_nx_s;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            result_q <= sat_res_s;
            dz_q     <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = (state_q == ST_DIV);
  assign done_o = done_q;
  assign quot_o = result_q;
  assign dz_o   = dz_q;

endmodule

// File: rtl/hssim_score_acc.sv
// HSSIM frame-score accumulator: sums numerator/denominator lanes over a
// frame, hands the totals to a serial divider and presents the Q(FRAC_BITS)
// score on a valid/ready output. Accumulation of the next frame overlaps
// the division of the previous one.
// Build option HSSIM_SCORE_ROUND_EN selects round-half-up in the divider.
module hssim_score_acc
  import hssim_pkg::*;
#(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int NUMR_BIT_WIDTH  = 36,
  parameter int DENR_BIT_WIDTH  = 36,
  parameter int FRAC_BITS       = 16,
  parameter int SCORE_WIDTH     = FRAC_BITS + 2
) (
  input  logic                                      clk,
  input  logic                                      aresetn,
  input  logic                                      stall,
  input  logic                                      in_valid,
  input  logic [NUMR_BIT_WIDTH*PIXELS_PER_BEAT-1:0] numr_in,
  input  logic [DENR_BIT_WIDTH*PIXELS_PER_BEAT-1:0] denr_in,
  output logic [SCORE_WIDTH-1:0]                    score,
  output logic                                      score_valid,
  input  logic                                      score_ready,
  output logic                                      div_zero,
  output logic                                      overrun
);

  localparam int BPF  = beats_per_frame(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int ACCW = acc_width(NUMR_BIT_WIDTH, DENR_BIT_WIDTH, IMAGE_DIM);
  localparam int CNTW = (BPF > 1) ? clog2(BPF) : 1;
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BPF - 1);

  logic [CNTW-1:0]        beat_cnt_q;
  logic [CNTW-1:0]        beat_cnt_d;
  logic                   s1_valid_q;
  logic                   s1_last_q;
  logic [ACCW-1:0]        s1_numr_q;
  logic [ACCW-1:0]        s1_denr_q;
  logic [ACCW-1:0]        numr_lane_sum_d;
  logic [ACCW-1:0]        denr_lane_sum_d;
  logic [ACCW-1:0]        acc_n_q;
  logic [ACCW-1:0]        acc_d_q;
  logic [ACCW-1:0]        op_n_q;
  logic [ACCW-1:0]        op_d_q;
  logic                   start_q;
  logic [SCORE_WIDTH-1:0] score_q;
  logic                   score_valid_q;
  logic                   div_zero_q;
  logic                   overrun_q;

  logic                   beat_take_s;
  logic [ACCW-1:0]        acc_n_sum_s;
  logic [ACCW-1:0]        acc_d_sum_s;
  logic                   div_busy_s;
  logic                   div_done_s;
  logic [SCORE_WIDTH-1:0] div_quot_s;
  logic                   div_dz_s;

  assign beat_take_s = in_valid & ~stall;
  assign acc_n_sum_s = acc_n_q + s1_numr_q;
  assign acc_d_sum_s = acc_d_q + s1_denr_q;

  // Beat counter next state: advance on an accepted beat, wrap at frame end
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (beat_take_s) begin
      if (beat_cnt_q == LAST_BEAT) begin
        beat_cnt_d = {CNTW{1'b0}};
      end else begin
        beat_cnt_d = beat_cnt_q + CNTW'(1);
      end
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  // Sign-extended sums across the lanes of the current beat
  always_comb begin
    numr_lane_sum_d = {ACCW{1'b0}};
    denr_lane_sum_d = {ACCW{1'b0}};
    for (int i = 0; i < PIXELS_PER_BEAT; i++) begin
      numr_lane_sum_d = numr_lane_sum_d
        + {{(ACCW-NUMR_BIT_WIDTH){numr_in[i*NUMR_BIT_WIDTH + NUMR_BIT_WIDTH - 1]}},
           numr_in[i*NUMR_BIT_WIDTH +: NUMR_BIT_WIDTH]};
      denr_lane_sum_d = denr_lane_sum_d
        + {{(ACCW-DENR_BIT_WIDTH){denr_in[i*DENR_BIT_WIDTH + DENR_BIT_WIDTH - 1]}},
           denr_in[i*DENR_BIT_WIDTH +: DENR_BIT_WIDTH]};
    end
  end

  // Stage 1: register lane sums, frame-end marker and beat counter; frozen by stall
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      beat_cnt_q <= {CNTW{1'b0}};
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_numr_q  <= {ACCW{1'b0}};
      s1_denr_q  <= {ACCW{1'b0}};
    end else if (!stall) begin
      beat_cnt_q <= beat_cnt_d;
      s1_valid_q <= in_valid;
      s1_last_q  <= (beat_cnt_q == LAST_BEAT);
      s1_numr_q  <= numr_lane_sum_d;
      s1_denr_q  <= denr_lane_sum_d;
    end
  end

  // Stage 2: frame accumulation; at frame end hand totals to the divider
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      acc_n_q <= {ACCW{1'b0}};
      acc_d_q <= {ACCW{1'b0}};
      op_n_q  <= {ACCW{1'b0}};
      op_d_q  <= {ACCW{1'b0}};
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (!stall && s1_valid_q) begin
        if (s1_last_q) begin
          op_n_q  <= acc_n_sum_s;
          op_d_q  <= acc_d_sum_s;
          acc_n_q <= {ACCW{1'b0}};
          acc_d_q <= {ACCW{1'b0}};
          start_q <= 1'b1;
        end else begin
          acc_n_q <= acc_n_sum_s;
          acc_d_q <= acc_d_sum_s;
        end
      end
    end
  end

  hssim_serial_div #(
    .ACC_WIDTH  (ACCW),
    .FRAC_BITS  (FRAC_BITS),
    .SCORE_WIDTH(SCORE_WIDTH)
  ) u_div (
    .clk    (clk),
    .aresetn(aresetn),
    .start_i(start_q),
    .num_i  (op_n_q),
    .den_i  (op_d_q),
    .busy_o (div_busy_s),
    .done_o (div_done_s),
    .quot_o (div_quot_s),
    .dz_o   (div_dz_s)
  );

  // Output handshake: load results, hold until accepted, flag lost results
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      score_q       <= {SCORE_WIDTH{1'b0}};
      score_valid_q <= 1'b0;
      div_zero_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      if (div_done_s) begin
        score_q       <= div_quot_s;
        div_zero_q    <= div_dz_s;
        score_valid_q <= 1'b1;
        if (score_valid_q && !score_ready) begin
          overrun_q <= 1'b1;
        end
      end else if (score_valid_q && score_ready) begin
        score_valid_q <= 1'b0;
      end
      if (start_q && div_busy_s) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign score       = score_q;
  assign score_valid = score_valid_q;
  assign div_zero    = div_zero_q;
  assign overrun     = overrun_q;

endmodule

// File: doc/hssim_score_acc.md
Name: hssim_score_acc

Overview:
- Sits directly downstream of the HSSIM stage and consumes its per-pixel signed numerator and denominator lanes.
- Sums each lane set over a full frame, then computes the frame score with a serial divider: score = sum(numr) / sum(denr), signed fixed point Q(FRAC_BITS).
- Presents the score on a valid/ready output to the fusion-weight logic.
- Accumulation of the next frame overlaps the division of the previous one.

Parameters:
- PIXELS_PER_BEAT, 16, lanes per beat.
- IMAGE_DIM, 512, frame is IMAGE_DIM x IMAGE_DIM pixels.
- NUMR_BIT_WIDTH, 36, signed width of one numerator lane.
- DENR_BIT_WIDTH, 36, signed width of one denominator lane.
- FRAC_BITS, 16, fractional bits of the score.
- SCORE_WIDTH, FRAC_BITS+2, signed score width (range [-2,2)).
- BEATS_PER_FRAME, IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT, derived, do not override.
- ACC_WIDTH, max(NUMR_BIT_WIDTH,DENR_BIT_WIDTH)+clog2(IMAGE_DIM*IMAGE_DIM)+1, derived frame-sum width.

Ports:
- clk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- stall  in  1  freezes the input pipeline and beat counter.
- in_valid  in  1  numr_in/denr_in carry a beat.
- numr_in  in  NUMR_BIT_WIDTH*PIXELS_PER_BEAT  signed lanes, lane 0 in LSBs.
- denr_in  in  DENR_BIT_WIDTH*PIXELS_PER_BEAT  signed lanes.
- score  out  SCORE_WIDTH  signed Q(FRAC_BITS) frame score.
- score_valid  out  1  score held valid until accepted.
- score_ready  in  1  consumer accepts score.
- div_zero  out  1  current score came from sum(denr)==0.
- overrun  out  1  sticky; a result or frame was lost.

Behaviour:
- Reset: clk and aresetn only, synchronous, active-low. All registers clear. score=0, score_valid=0, div_zero=0, overrun=0, beat counter=0, FSM=IDLE. Reset mid-frame or mid-divide discards all partial state.
- Beat acceptance: a beat is taken when in_valid=1 and stall=0.
- Stage 1 (1 cycle): sign-extended lane sums of numr and denr are registered, together with last_beat = (beat_cnt == BEATS_PER_FRAME-1).
- Stage 2 (1 cycle): the frame accumulators add the stage-1 sums. On last_beat, the final totals are copied to the divider operand registers, the accumulators restart from 0, and a start pulse is issued.
- Stall: stall holds both stages and the counter; the divider and output logic are not affected by stall.
- Beat counter: wraps to 0 after BEATS_PER_FRAME-1.
- FSM states: IDLE, DIV, DONE.
  - IDLE -> DIV on start.
  - DIV runs a restoring divide on magnitudes: dividend |N|<<FRAC_BITS, divisor |D|, one quotient bit per cycle, DIV_CYCLES = ACC_WIDTH+FRAC_BITS.
  - DIV -> DONE: the quotient sign is applied (sign(N) xor sign(D)), then the result saturates to SCORE_WIDTH signed.
  - DONE: the result loads into score and score_valid=1 in the same cycle; FSM -> IDLE.
- Latency: score_valid rises DIV_CYCLES+3 cycles after the clock that accepted the last beat, with no stall.
- D==0: the divider is skipped. score = +max (0x1FFFF for the default width), div_zero=1, score_valid 3 cycles after the last beat.
- Output handshake: score, div_zero and score_valid are held until score_valid && score_ready; on that cycle score_valid drops next clock.
- A new result arriving while score_valid=1 and not accepted overwrites score, keeps score_valid=1, and sets overrun.
- Simultaneous accept and new result: the new result is loaded, score_valid stays 1, overrun is not set.
- A start arriving while the FSM is in DIV drops that frame's totals and sets overrun; accumulation of the following frame still proceeds.
- Constraint: BEATS_PER_FRAME >= DIV_CYCLES+3 guarantees no drops.

Optional Feature:
- Macro: HSSIM_SCORE_ROUND_EN.
- Defined: |D|>>1 is added to the shifted dividend before division, giving round-half-up on magnitude.
- Undefined: quotient truncates toward zero.
- Saturation and D==0 handling are identical in both builds.

Decomposition:
- Package hssim_pkg holds:
  - clog2 function;
  - ACC_WIDTH / BEATS_PER_FRAME / DIV_CYCLES derivation functions;
  - FSM state enum;
  - SCORE_MAX/SCORE_MIN constants for saturation.
- Sub-module: hssim_serial_div. It is a parameterised restoring signed divider with a start/done pulse interface and a zero-divisor flag. The top keeps lane summation, the counter, accumulators and the output handshake.

Test Plan (IMAGE_DIM=8, PIXELS_PER_BEAT=4, FRAC_BITS=16 -> 16 beats/frame):
- All lanes numr=1, denr=2, score_ready=1 -> score=32768 (0.5), div_zero=0, valid exactly DIV_CYCLES+3 cycles after beat 16.
- numr=-1, denr=4 -> score=-16384; numr=3, denr=1 -> saturates to 131071.
- denr=0 in all lanes -> score=131071, div_zero=1, valid 3 cycles after last beat.
- numr=2, denr=3 -> 43690 without HSSIM_SCORE_ROUND_EN, 43691 with it.
- score_ready=0 across two frames -> second score replaces first, overrun=1, only one accept handshake.
- stall asserted for 5 cycles mid-frame plus in_valid gaps -> identical score to the unstalled run.
- aresetn low on beat 7 -> outputs 0; a following clean frame gives the correct score.
